// File: rtl/pdm_tx.sv
// rtl/pdm_tx.sv - first-order sigma-delta PDM transmitter with input sample FIFO and generated bit clock
module pdm_tx #(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [15:0]   bits_num,
    input  logic [7:0]    clk_div,
    output logic          pdm_clk,
    output logic          dout,
    output logic          busy,
    output logic          underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          out_en;
    logic          full, empty, push, pop;
    logic [DW-1:0] acc, cur;
    logic [7:0]    div_cntr;
    logic [15:0]   bit_cntr;
    logic          start, half_done, tick, reload;
    logic [DW:0]   sum;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign s_ready = out_en && !full;
    assign push    = s_valid && s_ready;
    assign busy    = (state == RUN);

    assign half_done = (div_cntr >= clk_div);
    assign tick      = (state == RUN) && enable && half_done && pdm_clk;
    assign reload    = tick && (bit_cntr >= bits_num);
    assign pop       = start || (reload && !empty);
    assign sum       = {1'b0, acc} + {1'b0, cur};

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !empty) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // out_en keeps s_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            out_en <= 1'b0;
        end else begin
            out_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            cur      <= '0;
            div_cntr <= '0;
            bit_cntr <= '0;
            pdm_clk  <= 1'b0;
            dout     <= 1'b0;
            underrun <= 1'b0;
        end else if (start) begin
            cur      <= mem[rd_ptr[AW-1:0]];
            acc      <= '0;
            div_cntr <= '0;
            bit_cntr <= '0;
            pdm_clk  <= 1'b0;
            dout     <= 1'b0;
            underrun <= 1'b0;
        end else if (state == RUN && enable) begin
            underrun <= 1'b0;
            if (half_done) begin
                div_cntr <= '0;
                pdm_clk  <= !pdm_clk;
            end else begin
                div_cntr <= div_cntr + 8'd1;
            end
            // Falling bit-clock edge: emit carry, then advance the sample schedule.
            if (tick) begin
                acc  <= sum[DW-1:0];
                dout <= sum[DW];
                if (reload) begin
                    bit_cntr <= '0;
                    if (!empty) begin
                        cur <= mem[rd_ptr[AW-1:0]];
                    end else begin
                        underrun <= 1'b1;
                    end
                end else begin
                    bit_cntr <= bit_cntr + 16'd1;
                end
            end
        end else begin
            acc      <= '0;
            div_cntr <= '0;
            bit_cntr <= '0;
            pdm_clk  <= 1'b0;
            dout     <= 1'b0;
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_tx.sv
// tb/tb_pdm_tx.sv - scoreboard bench for pdm_tx against an arithmetic sigma-delta model
module tb_pdm_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] bits_num = '0;
    logic [7:0]  clk_div = '0;
    logic        pdm_clk, dout, busy, underrun;

    pdm_tx #(.DW(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .bits_num(bits_num), .clk_div(clk_div),
        .pdm_clk(pdm_clk), .dout(dout), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic u;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] smp[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          ticks = 0;
    int          cur_div = 0;
    bit          mon_on = 1'b0;

    function automatic void chk(string name, longint act, longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: every falling bit-clock edge while busy is one emitted bit.
    logic prev_pdm = 1'b0;
    logic busy_q = 1'b0;
    int   cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (busy && !busy_q) cyc = 0;
            else cyc++;
            if (busy && prev_pdm && !pdm_clk) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tick", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", dout, e.b);
                    chk("underrun_tick", underrun, e.u);
                    chk("bit_period", cyc, 2 * (cur_div + 1));
                end
                cyc = 0;
                ticks++;
            end else if (busy) begin
                chk("underrun_idle", underrun, 0);
            end
        end
        prev_pdm = pdm_clk;
        busy_q   = busy;
    end

    task automatic push(input logic [15:0] v);
        int   b = 50;
        logic ok;
        s_data  = v;
        s_valid = 1'b1;
        do begin
            ok = s_ready;
            @(negedge clk); #1;
            b--;
        end while (!ok && b > 0);
        s_valid = 1'b0;
        chk("push_accept", ok, 1);
    endtask

    task automatic session(input int n, input int d, input int t);
        int   k = smp.size();
        int   acc = 0;
        int   si;
        int   budget;
        exp_t e;
        bits_num = n[15:0];
        clk_div  = d[7:0];
        cur_div  = d;
        for (int tt = 1; tt <= t; tt++) begin
            si = (tt - 1) / (n + 1);
            if (si > k - 1) si = k - 1;
            acc = acc + int'(smp[si]);
            e.b = (acc >= 65536);
            acc = acc % 65536;
            e.u = ((tt % (n + 1)) == 0) && ((tt / (n + 1)) >= k);
            exp_q.push_back(e);
        end
        for (int i = 0; i < k && i < 4; i++) push(smp[i]);
        if (k >= 4) chk("s_ready_full", s_ready, 0);
        chk("idle_busy", busy, 0);
        ticks  = 0;
        mon_on = 1'b1;
        enable = 1'b1;
        for (int i = 4; i < k; i++) push(smp[i]);
        budget = (t + 1) * 2 * (d + 1) + 40;
        while (ticks < t && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        chk("session_ticks", ticks, t);
        chk("busy_run", busy, 1);
        enable = 1'b0;
        @(negedge clk); #1;
        chk("off_busy", busy, 0);
        chk("off_pdm_clk", pdm_clk, 0);
        chk("off_dout", dout, 0);
        chk("exp_left", exp_q.size(), 0);
        mon_on = 1'b0;
        exp_q.delete();
        @(negedge clk); #1;
    endtask

    initial begin
        int k, n, d, t;
        #12;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pdm_clk", pdm_clk, 0);
        chk("rst_dout", dout, 0);
        chk("rst_underrun", underrun, 0);
        @(negedge clk); #1;
        rst = 1'b1;
        chk("release_s_ready", s_ready, 0);
        @(posedge clk); #1;
        chk("first_edge_s_ready", s_ready, 1);
        @(negedge clk); #1;

        smp = '{16'h8000};
        session(15, 0, 16);
        smp = '{16'h4000, 16'hFFFF, 16'h0000};
        session(15, 0, 48);
        smp.delete();
        for (int i = 0; i < 5; i++) smp.push_back(16'($urandom_range(0, 65535)));
        n = $urandom_range(0, 5);
        d = $urandom_range(0, 3);
        session(n, d, 6 * (n + 1));
        smp = '{16'($urandom_range(0, 65535))};
        session(3, 2, 12);
        for (int r = 0; r < 4; r++) begin
            smp.delete();
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) smp.push_back(16'($urandom_range(0, 65535)));
            n = $urandom_range(0, 6);
            d = $urandom_range(0, 3);
            t = k * (n + 1) + $urandom_range(0, n + 2);
            session(n, d, t);
        end

        push(16'h1234);
        push(16'h5678);
        bits_num = 16'd100;
        clk_div  = 8'd0;
        enable   = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("pre_reset_busy", busy, 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_pdm_clk", pdm_clk, 0);
        chk("async_dout", dout, 0);
        chk("async_s_ready", s_ready, 0);
        chk("async_underrun", underrun, 0);
        enable = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        chk("rel_s_ready", s_ready, 0);
        @(posedge clk); #1;
        chk("rel_edge_s_ready", s_ready, 1);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("fifo_cleared_busy", busy, 0);
        enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
